// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, taken-branch, multi-cycle MUL
// and data-memory wait hazards by driving stage enables, bubbles and flushes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CPU not started; every stage enable held low
// RUN      | normal issue; hazards detected and prioritised here
// MUL_BUSY | MUL still occupies EX; mcnt counts remaining hold cycles
// MEM_WAIT | data memory request outstanding; whole pipe frozen
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  IFID_Rs_i,
    input  logic [4:0]  IFID_Rt_i,
    input  logic [4:0]  IDEX_Rt_i,
    input  logic        IDEX_MemRead_i,
    input  logic        IDEX_Mul_i,
    input  logic        Branch_taken_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    output logic        PC_Write_o,
    output logic        IFID_Write_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Write_o,
    output logic        IDEX_Bubble_o,
    output logic        EXMEM_Write_o,
    output logic        EXMEM_Bubble_o,
    output logic        MEMWB_Bubble_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, MUL_BUSY, MEM_WAIT} state_t;

    localparam bit         MUL_STALLS = (MUL_LAT > 1);
    localparam int         MCNT_INIT_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [3:0] MCNT_INIT = MCNT_INIT_I[3:0];

    state_t      state_q, state_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_wait, load_use;

    assign mem_wait = dmem_req_i & ~dmem_ack_i;
    assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_d        = state_q;
        mcnt_d         = mcnt_q;
        PC_Write_o     = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Write_o   = 1'b1;
        IDEX_Bubble_o  = 1'b0;
        EXMEM_Write_o  = 1'b1;
        EXMEM_Bubble_o = 1'b0;
        MEMWB_Bubble_o = 1'b0;

        case (state_q)
            IDLE: begin
                PC_Write_o    = 1'b0;
                IFID_Write_o  = 1'b0;
                IDEX_Write_o  = 1'b0;
                EXMEM_Write_o = 1'b0;
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (mem_wait) begin
                    PC_Write_o     = 1'b0;
                    IFID_Write_o   = 1'b0;
                    IDEX_Write_o   = 1'b0;
                    EXMEM_Write_o  = 1'b0;
                    MEMWB_Bubble_o = 1'b1;
                    state_d        = MEM_WAIT;
                end else if (IDEX_Mul_i && MUL_STALLS) begin
                    PC_Write_o     = 1'b0;
                    IFID_Write_o   = 1'b0;
                    IDEX_Write_o   = 1'b0;
                    EXMEM_Bubble_o = 1'b1;
                    mcnt_d         = MCNT_INIT;
                    state_d        = MUL_BUSY;
                end else if (load_use) begin
                    PC_Write_o    = 1'b0;
                    IFID_Write_o  = 1'b0;
                    IDEX_Bubble_o = 1'b1;
                end else if (Branch_taken_i) begin
                    IFID_Flush_o = 1'b1;
                end
            end
            MUL_BUSY: begin
                // A memory stall on the final MUL cycle keeps us here so the MUL is not re-issued.
                if ((mcnt_q != 4'd0) || mem_wait) begin
                    PC_Write_o   = 1'b0;
                    IFID_Write_o = 1'b0;
                    IDEX_Write_o = 1'b0;
                    if (mem_wait) begin
                        EXMEM_Write_o  = 1'b0;
                        MEMWB_Bubble_o = 1'b1;
                    end else begin
                        EXMEM_Bubble_o = 1'b1;
                        mcnt_d         = mcnt_q - 4'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack_i) begin
                    PC_Write_o     = 1'b0;
                    IFID_Write_o   = 1'b0;
                    IDEX_Write_o   = 1'b0;
                    EXMEM_Write_o  = 1'b0;
                    MEMWB_Bubble_o = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((state_q != IDLE) && !PC_Write_o && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mcnt_q      <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle table from reset plus hand sequences for
// MUL_LAT=1, asynchronous reset mid-MUL and stall counter saturation.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst, start, memrd, mul, br, req, ack;
    logic [4:0] rs, rt, exrt;

    logic pc_w, ifid_w, flush, idex_w, idex_b, exmem_w, exmem_b, memwb_b;
    logic [15:0] cnt;
    logic pc_w1, ifid_w1, flush1, idex_w1, idex_b1, exmem_w1, exmem_b1, memwb_b1;
    logic [15:0] cnt1;
    logic [7:0] o4, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .IFID_Rs_i(rs), .IFID_Rt_i(rt), .IDEX_Rt_i(exrt),
        .IDEX_MemRead_i(memrd), .IDEX_Mul_i(mul), .Branch_taken_i(br),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_Write_o(pc_w), .IFID_Write_o(ifid_w), .IFID_Flush_o(flush),
        .IDEX_Write_o(idex_w), .IDEX_Bubble_o(idex_b),
        .EXMEM_Write_o(exmem_w), .EXMEM_Bubble_o(exmem_b),
        .MEMWB_Bubble_o(memwb_b), .stall_cnt_o(cnt)
    );

    hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .IFID_Rs_i(rs), .IFID_Rt_i(rt), .IDEX_Rt_i(exrt),
        .IDEX_MemRead_i(memrd), .IDEX_Mul_i(mul), .Branch_taken_i(br),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_Write_o(pc_w1), .IFID_Write_o(ifid_w1), .IFID_Flush_o(flush1),
        .IDEX_Write_o(idex_w1), .IDEX_Bubble_o(idex_b1),
        .EXMEM_Write_o(exmem_w1), .EXMEM_Bubble_o(exmem_b1),
        .MEMWB_Bubble_o(memwb_b1), .stall_cnt_o(cnt1)
    );

    // {PC, IFID_W, FLUSH, IDEX_W, IDEX_B, EXMEM_W, EXMEM_B, MEMWB_B}
    assign o4 = {pc_w, ifid_w, flush, idex_w, idex_b, exmem_w, exmem_b, memwb_b};
    assign o1 = {pc_w1, ifid_w1, flush1, idex_w1, idex_b1, exmem_w1, exmem_b1, memwb_b1};

    localparam logic [7:0] IDL  = 8'b0000_0000;
    localparam logic [7:0] DEF  = 8'b1101_0100;
    localparam logic [7:0] LU   = 8'b0001_1100;
    localparam logic [7:0] MULS = 8'b0000_0110;
    localparam logic [7:0] FRZ  = 8'b0000_0001;
    localparam logic [7:0] BR   = 8'b1111_0100;

    typedef struct {
        logic       st;
        logic [4:0] rs, rt, exrt;
        logic       mr, mul, br, req, ack;
        logic [7:0] eo;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic st, logic [4:0] a_rs, logic [4:0] a_rt, logic [4:0] a_exrt,
                                logic a_mr, logic a_mul, logic a_br, logic a_req, logic a_ack,
                                logic [7:0] eo, logic [15:0] ec);
        vec_t v;
        v.st = st; v.rs = a_rs; v.rt = a_rt; v.exrt = a_exrt;
        v.mr = a_mr; v.mul = a_mul; v.br = a_br; v.req = a_req; v.ack = a_ack;
        v.eo = eo; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        start = v.st; rs = v.rs; rt = v.rt; exrt = v.exrt;
        memrd = v.mr; mul = v.mul; br = v.br; req = v.req; ack = v.ack;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t idle_v, mul_v, frz_v, start_v;

    initial begin
        rst = 1'b1; start = 0; rs = 0; rt = 0; exrt = 0;
        memrd = 0; mul = 0; br = 0; req = 0; ack = 0;

        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL,  0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  0);
        vecs[2]  = mk(0, 5, 0, 5, 1, 0, 0, 0, 0, LU,   0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  1);
        vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, DEF,  1);
        vecs[5]  = mk(0, 3, 7, 7, 1, 0, 0, 0, 0, LU,   1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 2);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 3);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 4);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, DEF,  5);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  5);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  5);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  6);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  7);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF,  8);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF,  8);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   8);
        vecs[17] = mk(0, 5, 0, 5, 1, 0, 1, 0, 0, LU,   8);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ,  9);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, DEF,  10);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 10);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ,  11);
        vecs[22] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, MULS, 12);
        vecs[23] = mk(0, 4, 0, 4, 1, 1, 0, 0, 0, MULS, 13);
        vecs[24] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, DEF,  14);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  14);

        idle_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
        start_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
        mul_v   = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, IDL, 0);
        frz_v   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, IDL, 0);

        #12;
        chk("reset_outputs", {24'd0, o4}, {24'd0, IDL});
        chk("reset_cnt", {16'd0, cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i]);
            chk($sformatf("vec%0d_out", i), {24'd0, o4}, {24'd0, vecs[i].eo});
            chk($sformatf("vec%0d_cnt", i), {16'd0, cnt}, {16'd0, vecs[i].ec});
        end

        // MUL_LAT=1: a MUL never stalls
        do_reset();
        drive(start_v);
        for (int i = 0; i < 3; i++) begin
            drive(mul_v);
            chk($sformatf("lat1_mul%0d_out", i), {24'd0, o1}, {24'd0, DEF});
        end
        drive(idle_v);
        chk("lat1_cnt", {16'd0, cnt1}, 32'd0);

        // Asynchronous reset while MUL_BUSY holds mcnt=1
        do_reset();
        drive(start_v);
        drive(mul_v);
        chk("amul_first", {24'd0, o4}, {24'd0, MULS});
        drive(mul_v);
        drive(mul_v);
        chk("amul_mcnt1_out", {24'd0, o4}, {24'd0, MULS});
        chk("amul_mcnt1_cnt", {16'd0, cnt}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out", {24'd0, o4}, {24'd0, IDL});
        chk("async_rst_cnt", {16'd0, cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturate the stall counter with a long memory wait
        drive(start_v);
        for (int i = 0; i < 65534; i++) drive(frz_v);
        drive(frz_v);
        chk("sat_fffe", {16'd0, cnt}, 32'h0000_FFFE);
        chk("sat_freeze", {24'd0, o4}, {24'd0, FRZ});
        drive(frz_v);
        chk("sat_ffff", {16'd0, cnt}, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) drive(frz_v);
        chk("sat_hold", {16'd0, cnt}, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
